// File: rtl/jtkcpu_pcq.sv
// jtkcpu_pcq -- program-counter unit with opcode prefetch queue.
//
// Keeps the logical PC (address of the next unconsumed opcode byte) and a
// fetch PC. Opcode bytes are prefetched into a DEPTH-entry FIFO, one bus
// fetch outstanding at a time. Jumps, relative branches and stack pulls
// flush the queue and redirect both PCs. All PC arithmetic wraps modulo 2**AW.
//
// Optional build macro: JTKCPU_PCQ_BYPASS_EN
//   defined   : an accepted ack into an empty queue is presented on op_* in
//               the ack cycle and may be popped there without being stored.
//   undefined : op_* come from the FIFO registers only (1-cycle latency).
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   i_cen           clock enable, state only changes on i_cen=1 cycles
//   i_halt          suppresses new fetch requests
//   o_fetch_req     registered fetch request
//   o_fetch_addr    fetch address, stable while o_fetch_req=1
//   i_fetch_ack     fetch done, i_fetch_data valid this cycle
//   i_fetch_data    fetched byte
//   o_op_valid      queue head valid
//   o_op_data       queue head byte
//   o_op_pc         logical PC, address of o_op_data
//   i_op_rd         pop head, logical PC +1
//   i_br8/i_br16    redirect to o_op_pc + sext(i_boff[7:0] / i_boff[15:0])
//   i_jmp           redirect to i_jaddr (priority jmp > br16 > br8)
//   i_boff          branch offset
//   i_jaddr         absolute redirect target
module jtkcpu_pcq #(
    parameter int unsigned    AW     = 16,
    parameter int unsigned    DW     = 8,
    parameter int unsigned    DEPTH  = 4,
    parameter logic [AW-1:0]  RST_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_cen,
    input  logic          i_halt,
    output logic          o_fetch_req,
    output logic [AW-1:0] o_fetch_addr,
    input  logic          i_fetch_ack,
    input  logic [DW-1:0] i_fetch_data,
    output logic          o_op_valid,
    output logic [DW-1:0] o_op_data,
    output logic [AW-1:0] o_op_pc,
    input  logic          i_op_rd,
    input  logic          i_br8,
    input  logic          i_br16,
    input  logic          i_jmp,
    input  logic [15:0]   i_boff,
    input  logic [AW-1:0] i_jaddr
);
    localparam int AI = $clog2(DEPTH);
    localparam int PW = AI + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr, r_rd;
    logic [AW-1:0] r_pc, r_fpc;
    logic          r_req, r_discard;

    logic [PW-1:0] w_count;
    logic          w_empty, w_ack, w_redir, w_byp, w_pop, w_pop_fifo, w_push;
    logic          w_req_nxt;
    logic [AW-1:0] w_target;

    assign w_count = r_wr - r_rd;
    assign w_empty = (w_count == '0);
    assign w_ack   = i_cen & i_fetch_ack & r_req;
    assign w_redir = i_cen & (i_jmp | i_br16 | i_br8);

    always_comb begin
        w_target = i_jaddr;
        if (i_jmp)
            w_target = i_jaddr;
        else if (i_br16)
            w_target = r_pc + AW'($signed(i_boff));
        else
            w_target = r_pc + AW'($signed(i_boff[7:0]));
    end

`ifdef JTKCPU_PCQ_BYPASS_EN
    // While empty and not discarding, the fetch PC equals the logical PC, so
    // the byte on the bus is exactly the one the sequencer is waiting for.
    assign w_byp = w_empty & w_ack & ~r_discard;
`else
    assign w_byp = 1'b0;
`endif

    assign o_op_valid   = ~w_empty | w_byp;
    assign o_op_data    = w_byp ? i_fetch_data : r_mem[r_rd[AI-1:0]];
    assign o_op_pc      = r_pc;
    assign o_fetch_req  = r_req;
    assign o_fetch_addr = r_fpc;

    assign w_pop      = i_cen & i_op_rd & o_op_valid & ~w_redir;
    assign w_pop_fifo = w_pop & ~w_empty;
    assign w_push     = w_ack & ~r_discard & ~w_redir & ~(w_byp & w_pop);

    // With no fetch outstanding the occupancy alone decides; a redirect
    // empties the queue, so it may request straight away.
    always_comb begin
        w_req_nxt = r_req;
        if (r_req)
            w_req_nxt = ~w_ack;
        else
            w_req_nxt = ~i_halt & (w_redir | (w_count < PW'(DEPTH)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req     <= 1'b0;
            r_discard <= 1'b0;
            r_pc      <= RST_PC;
            r_fpc     <= RST_PC;
            r_wr      <= '0;
            r_rd      <= '0;
        end else if (i_cen) begin
            r_req <= w_req_nxt;
            if (w_redir) begin
                r_pc <= w_target;
                r_wr <= '0;
                r_rd <= '0;
                // fetch_addr must stay put while the stale request is in
                // flight; the target is parked in r_pc until that ack.
                if (r_req & ~w_ack) begin
                    r_discard <= 1'b1;
                end else begin
                    r_discard <= 1'b0;
                    r_fpc     <= w_target;
                end
            end else begin
                if (w_pop)      r_pc <= r_pc + AW'(1);
                if (w_push)     r_wr <= r_wr + PW'(1);
                if (w_pop_fifo) r_rd <= r_rd + PW'(1);
                if (w_ack) begin
                    if (r_discard) begin
                        r_discard <= 1'b0;
                        r_fpc     <= r_pc;
                    end else begin
                        r_fpc <= r_fpc + AW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_cen && w_push)
            r_mem[r_wr[AI-1:0]] <= i_fetch_data;
    end
endmodule
